lsu_split: RTL and testbench

Load/store unit that sits directly upstream of the byte-masked data memory. It converts core load/store requests into word-addressed memory accesses with byte masks and lane-aligned write data, and returns sign- or zero-extended load data. Accesses that cross a 32-bit word boundary are split into two back-to-back memory accesses by a small FSM, which stalls the core for one cycle.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/lsu_split.sv | 145 ++++++++++++++
 tb/tb_lsu_split.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_pkg : shared types and decode helpers for the load/store unit        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } lsu_state_e;

    // Access size in bytes from the low funct3 bits.
    function automatic logic [2:0] lsu_size(input logic [1:0] sz);
        case (sz)
            2'b00:   lsu_size = 3'd1;
            2'b01:   lsu_size = 3'd2;
            default: lsu_size = 3'd4;
        endcase
    endfunction

    function automatic logic lsu_legal(input logic we, input logic [2:0] f3);
        case (f3)
            LSU_B, LSU_H, LSU_W: lsu_legal = 1'b1;
            LSU_BU, LSU_HU:      lsu_legal = !we;
            default:             lsu_legal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_lane_align : byte-mask, write-lane shift and load extension          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu_lane_align (
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic        i_sign,
    input  logic        i_hi_sel,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo_data,
    input  logic [31:0] i_hi_data,
    output logic [3:0]  o_bmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [3:0]  w_base;
    logic [7:0]  w_mask8;
    logic [63:0] w_wdata64;
    logic [63:0] w_rdata64;

    always_comb begin
        case (i_size)
            3'd1:    w_base = 4'b0001;
            3'd2:    w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
    end

    // A 64-bit view covers both halves of a crossing access at once.
    assign w_mask8   = {4'b0000, w_base} << i_off;
    assign w_wdata64 = {32'h0, i_wdata} << {i_off, 3'b000};
    assign w_rdata64 = {i_hi_data, i_lo_data} >> {i_off, 3'b000};

    assign o_bmask = i_hi_sel ? w_mask8[7:4]     : w_mask8[3:0];
    assign o_wdata = i_hi_sel ? w_wdata64[63:32] : w_wdata64[31:0];

    always_comb begin
        case (i_size)
            3'd1:    o_rdata = {{24{i_sign & w_rdata64[7]}},  w_rdata64[7:0]};
            3'd2:    o_rdata = {{16{i_sign & w_rdata64[15]}}, w_rdata64[15:0]};
            default: o_rdata = w_rdata64[31:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_split.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_split : load/store unit splitting word-crossing accesses in two      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu_split
    import lsu_pkg::*;
#(
    parameter int WORD_AW = 9
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_e           r_state, w_next;
    logic                 r_we;
    logic [2:0]           r_funct3;
    logic [WORD_AW+1:0]   r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_lo;

    logic                 w_in_second;
    logic                 w_we;
    logic [2:0]           w_funct3;
    logic [WORD_AW+1:0]   w_addr;
    logic [31:0]          w_wdata;
    logic [1:0]           w_off;
    logic [2:0]           w_size;
    logic                 w_legal;
    logic                 w_cross;
    logic [WORD_AW-1:0]   w_word;
    logic [WORD_AW-1:0]   w_mem_word;
    logic                 w_active;
    logic                 w_capture;
    logic [3:0]           w_bmask;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_unused = ^i_addr[31:WORD_AW+2];

    // In SECOND the latched request drives everything; the core bus is ignored.
    assign w_in_second = (r_state == SECOND);
    assign w_we        = w_in_second ? r_we     : i_we;
    assign w_funct3    = w_in_second ? r_funct3 : i_funct3;
    assign w_addr      = w_in_second ? r_addr   : i_addr[WORD_AW+1:0];
    assign w_wdata     = w_in_second ? r_wdata  : i_wdata;

    assign w_off   = w_addr[1:0];
    assign w_size  = lsu_size(w_funct3[1:0]);
    assign w_legal = lsu_legal(w_we, w_funct3);
    assign w_cross = ({1'b0, w_off} + w_size) > 3'd4;
    assign w_word  = w_addr[WORD_AW+1:2];

    always_comb begin
        w_next     = r_state;
        o_stall    = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        o_mem_wren = 1'b0;
        w_active   = 1'b0;
        w_capture  = 1'b0;
        w_mem_word = w_word;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    if (!w_legal) begin
                        o_err  = 1'b1;
                        o_done = 1'b1;
                    end else begin
                        w_active   = 1'b1;
                        o_mem_wren = i_we;
                        if (w_cross) begin
                            o_stall   = 1'b1;
                            w_capture = 1'b1;
                            w_next    = SECOND;
                        end else begin
                            o_done = 1'b1;
                        end
                    end
                end
            end
            SECOND: begin
                w_active   = 1'b1;
                o_mem_wren = r_we;
                o_done     = 1'b1;
                w_mem_word = w_word + 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    lsu_lane_align u_align (
        .i_off     (w_off),
        .i_size    (w_size),
        .i_sign    (!w_funct3[2]),
        .i_hi_sel  (w_in_second),
        .i_wdata   (w_wdata),
        .i_lo_data (w_in_second ? r_lo : i_mem_rdata),
        .i_hi_data (w_in_second ? i_mem_rdata : 32'h0),
        .o_bmask   (w_bmask),
        .o_wdata   (o_mem_wdata),
        .o_rdata   (w_rdata)
    );

    assign o_mem_bmask = w_active ? w_bmask : 4'b0000;
    assign o_rdata     = (w_active && o_done && !w_we) ? w_rdata : 32'h0;
    assign o_mem_addr  = {{(32-WORD_AW){1'b0}}, w_mem_word};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_lo     <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_we     <= i_we;
                r_funct3 <= i_funct3;
                r_addr   <= i_addr[WORD_AW+1:0];
                r_wdata  <= i_wdata;
                r_lo     <= i_mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_split.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_split : scoreboard bench for lsu_split with a byte-masked memory  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lsu_split;

    logic        i_clk;
    logic        i_reset;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [512];
    int          tests;
    int          fails;

    lsu_split #(.WORD_AW(9)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rdata     (o_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_bmask (o_mem_bmask),
        .o_mem_wren  (o_mem_wren),
        .i_mem_rdata (i_mem_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    assign i_mem_rdata = mem[o_mem_addr[8:0]];

    always @(posedge i_clk) begin
        if (o_mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_bmask[b]) mem[o_mem_addr[8:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        end
    end

    // Scoreboard: every completion pops the oldest expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset && o_done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_done: got done with empty scoreboard");
            end else begin
                e = sb.pop_front();
                if (o_err !== e.err || ((!e.we || e.err) && o_rdata !== e.rdata)) begin
                    fails++;
                    $display("FAIL sb_result: got err=%0b rdata=%h, want err=%0b rdata=%h",
                             o_err, o_rdata, e.err, e.rdata);
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        sb.push_back('{we: we, err: exp_err, rdata: exp_rdata});
        i_req    = 1'b1;
        i_we     = we;
        i_funct3 = f3;
        i_addr   = addr;
        i_wdata  = wdata;
    endtask

    // Issue one request and wait (bounded) for completion; reports cycles taken.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, output int cyc);
        drive(we, f3, addr, wdata, exp_rdata, exp_err);
        cyc = 0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (o_done) break;
            if (cyc >= 4) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: got no done after %0d cycles, want done", cyc);
                void'(sb.pop_front());
                break;
            end
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h10; i_wdata = 32'h0;
        @(negedge i_clk);
        tests++;
        if ({o_stall, o_done, o_err, o_mem_wren} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b, want 0000", {o_stall, o_done, o_err, o_mem_wren});
        end
        tests++;
        if (o_mem_bmask !== 4'b0000 || o_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got bmask=%b rdata=%h, want 0000/0", o_mem_bmask, o_rdata);
        end
        tests++;
        if (o_mem_addr !== 32'd4) begin
            fails++;
            $display("FAIL reset_addr: got %h, want 4", o_mem_addr);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic test_lw_aligned;
        int cyc;
        mem[4] = 32'hDEADBEEF;
        drive(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge i_clk);
        tests++;
        if (o_done !== 1'b1 || o_stall !== 1'b0 || o_mem_addr !== 32'd4 || o_mem_bmask !== 4'b1111) begin
            fails++;
            $display("FAIL lw_aligned: got done=%b stall=%b addr=%h bmask=%b, want 1/0/4/1111",
                     o_done, o_stall, o_mem_addr, o_mem_bmask);
        end
        @(posedge i_clk); #1;
        i_req = 1'b0;
        cyc = 0;
    endtask

    task automatic test_split_store;
        drive(1'b1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 1'b0);
        @(negedge i_clk);
        tests++;
        if (o_stall !== 1'b1 || o_done !== 1'b0 || o_mem_addr !== 32'd0 || o_mem_bmask !== 4'b1000
            || o_mem_wdata[31:24] !== 8'hEF || o_mem_wren !== 1'b1) begin
            fails++;
            $display("FAIL sh_first: got stall=%b done=%b addr=%h bmask=%b wd=%h, want 1/0/0/1000/EF",
                     o_stall, o_done, o_mem_addr, o_mem_bmask, o_mem_wdata[31:24]);
        end
        @(posedge i_clk); #1;
        i_req = 1'b0;
        i_addr = 32'h100;
        @(negedge i_clk);
        tests++;
        if (o_done !== 1'b1 || o_stall !== 1'b0 || o_mem_addr !== 32'd1 || o_mem_bmask !== 4'b0001
            || o_mem_wdata[7:0] !== 8'hBE || o_mem_wren !== 1'b1) begin
            fails++;
            $display("FAIL sh_second: got done=%b stall=%b addr=%h bmask=%b wd=%h, want 1/0/1/0001/BE",
                     o_done, o_stall, o_mem_addr, o_mem_bmask, o_mem_wdata[7:0]);
        end
        @(posedge i_clk); #1;
        tests++;
        if (mem[0] !== 32'hEF000000 || mem[1] !== 32'h000000BE) begin
            fails++;
            $display("FAIL sh_memory: got mem0=%h mem1=%h, want EF000000/000000BE", mem[0], mem[1]);
        end
    endtask

    task automatic test_loads;
        int cyc;
        mem[0] = 32'h80010000;
        mem[2] = 32'h0000007F;
        issue(1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF8001, 1'b0, cyc);
        issue(1'b0, 3'b101, 32'h2, 32'h0, 32'h00008001, 1'b0, cyc);
        issue(1'b0, 3'b000, 32'h8, 32'h0, 32'h0000007F, 1'b0, cyc);
        tests++;
        if (cyc != 1) begin
            fails++;
            $display("FAIL lb_latency: got %0d cycles, want 1", cyc);
        end
        i_req = 1'b0;
    endtask

    task automatic test_wrap;
        mem[511] = 32'h33445566;
        mem[0]   = 32'h77881122;
        drive(1'b0, 3'b010, 32'h7FE, 32'h0, 32'h11223344, 1'b0);
        @(negedge i_clk);
        tests++;
        if (o_stall !== 1'b1 || o_mem_addr !== 32'd511) begin
            fails++;
            $display("FAIL wrap_first: got stall=%b addr=%h, want 1/1FF", o_stall, o_mem_addr);
        end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        tests++;
        if (o_done !== 1'b1 || o_mem_addr !== 32'd0 || o_mem_bmask !== 4'b0011) begin
            fails++;
            $display("FAIL wrap_second: got done=%b addr=%h bmask=%b, want 1/0/0011",
                     o_done, o_mem_addr, o_mem_bmask);
        end
        @(posedge i_clk); #1;
        i_req = 1'b0;
    endtask

    task automatic test_err;
        logic [2:0] f3s [2];
        logic       wes [2];
        f3s[0] = 3'b011; wes[0] = 1'b0;
        f3s[1] = 3'b100; wes[1] = 1'b1;
        mem[4] = 32'hDEADBEEF;
        for (int k = 0; k < 2; k++) begin
            drive(wes[k], f3s[k], 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
            @(negedge i_clk);
            tests++;
            if (o_err !== 1'b1 || o_done !== 1'b1 || o_mem_wren !== 1'b0 || o_mem_bmask !== 4'b0000
                || o_stall !== 1'b0) begin
                fails++;
                $display("FAIL err_%0d: got err=%b done=%b wren=%b bmask=%b stall=%b, want 1/1/0/0000/0",
                         k, o_err, o_done, o_mem_wren, o_mem_bmask, o_stall);
            end
            @(posedge i_clk); #1;
        end
        i_req = 1'b0;
        tests++;
        if (mem[4] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL err_nowrite: got mem4=%h, want DEADBEEF", mem[4]);
        end
    endtask

    task automatic test_reset_second;
        mem[1] = 32'h0;
        mem[2] = 32'h0;
        drive(1'b1, 3'b010, 32'h5, 32'hAABBCCDD, 32'h0, 1'b0);
        @(negedge i_clk);
        tests++;
        if (o_stall !== 1'b1 || o_mem_bmask !== 4'b1110 || o_mem_addr !== 32'd1) begin
            fails++;
            $display("FAIL rst2_first: got stall=%b bmask=%b addr=%h, want 1/1110/1",
                     o_stall, o_mem_bmask, o_mem_addr);
        end
        @(posedge i_clk); #2;
        i_reset = 1'b1;
        i_req   = 1'b0;
        @(negedge i_clk);
        tests++;
        if (o_done !== 1'b0 || o_mem_wren !== 1'b0 || o_stall !== 1'b0 || o_mem_addr !== 32'd1) begin
            fails++;
            $display("FAIL rst2_abort: got done=%b wren=%b stall=%b addr=%h, want 0/0/0/1",
                     o_done, o_mem_wren, o_stall, o_mem_addr);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        tests++;
        if (mem[1] !== 32'hBBCCDD00 || mem[2] !== 32'h0) begin
            fails++;
            $display("FAIL rst2_memory: got mem1=%h mem2=%h, want BBCCDD00/0", mem[1], mem[2]);
        end
        tests++;
        if (sb.size() != 1) begin
            fails++;
            $display("FAIL rst2_pending: got %0d outstanding, want 1", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(1'b1, 3'b010, 32'h21, 32'h12345678, 32'h0, 1'b0, cyc);
        tests++;
        if (cyc != 2) begin fails++; $display("FAIL b2b_sw_cycles: got %0d, want 2", cyc); end
        issue(1'b0, 3'b010, 32'h21, 32'h0, 32'h12345678, 1'b0, cyc);
        tests++;
        if (cyc != 2) begin fails++; $display("FAIL b2b_lw_cycles: got %0d, want 2", cyc); end
        issue(1'b0, 3'b001, 32'h22, 32'h0, 32'h00003456, 1'b0, cyc);
        issue(1'b0, 3'b000, 32'h24, 32'h0, 32'h00000012, 1'b0, cyc);
        issue(1'b1, 3'b000, 32'h25, 32'h00000080, 32'h0, 1'b0, cyc);
        issue(1'b0, 3'b000, 32'h25, 32'h0, 32'hFFFFFF80, 1'b0, cyc);
        issue(1'b0, 3'b101, 32'h24, 32'h0, 32'h00008012, 1'b0, cyc);
        issue(1'b0, 3'b001, 32'h23, 32'h0, 32'h00001234, 1'b0, cyc);
        tests++;
        if (cyc != 2) begin fails++; $display("FAIL b2b_lh_cross_cycles: got %0d, want 2", cyc); end
        i_req = 1'b0;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_drain: got %0d outstanding, want 0", sb.size());
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int a = 0; a < 512; a++) mem[a] = 32'h0;
        test_reset();
        test_lw_aligned();
        test_split_store();
        test_loads();
        test_wrap();
        test_err();
        test_reset_second();
        test_back_to_back();
        repeat (2) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
